mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the cache request/wait protocol: the block that answers cache read and write requests and drives the `dwait` and `iwait` handshakes.
- Serves the data cache (`dREN`/`dWEN`) and the instruction cache (`iREN`) from an internal word-addressed RAM.
- Adds a programmable access latency and arbitrates with data-side priority.
- Releases each access by dropping the matching wait signal for exactly one cycle, so cache FSMs advance on `~wait`.
- Sits between the cache controllers and the memory model.

## Interface
- `LAT`, 2: wait cycles added per access (0..15).
- `DEPTH_W`, 10: log2 of RAM depth in 32-bit words.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `dREN` in 1: data read request, held until `~dwait`.
- `dWEN` in 1: data write request, held until `~dwait`.
- `daddr` in 32: data byte address.
- `dstore` in 32: data write word.
- `dload` out 32: data read word.
- `dwait` out 1: low only in the data completion cycle.
- `iREN` in 1: instruction read request.
- `iaddr` in 32: instruction byte address.
- `iload` out 32: instruction read word.
- `iwait` out 1: low only in the instruction completion cycle.

## Operation
- States and counter:
  - States: IDLE, DBUSY, IBUSY.
  - 4-bit down-counter `cnt`.
  - Latched request registers: `op` (read/write), `aidx` (index), `wdata`.
- IDLE:
  - If `dREN|dWEN`: latch `daddr[DEPTH_W+1:2]`, `dstore`, and op, then go to DBUSY with `cnt=LAT`. `dWEN` wins if both `dREN` and `dWEN` are high.
  - Else if `iREN`: latch `iaddr` index, then go to IBUSY with `cnt=LAT`.
  - Else stay in IDLE.
- DBUSY / IBUSY:
  - While the side's request is high and `cnt!=0`: decrement `cnt`.
  - At `cnt==0` with the request high (completion cycle):
    - Drop the side's wait signal.
    - Read: drive the load output with `mem[aidx]`.
    - Write: commit `mem[aidx]<=wdata` at the ending edge.
    - Go to IDLE.
  - Abort: if the side's request is low in any busy cycle, go to IDLE. No write, no completion.
- Input changes during busy: address, data and op changes are ignored; the latched values are used.
- Address mapping:
  - `addr[1:0]` ignored.
  - Bits above `DEPTH_W+1` ignored, so addresses wrap modulo depth.
- Outputs:
  - `dwait`/`iwait` are 1 in every non-completion cycle, including idle.
  - `dload`/`iload` are 0 outside their read completion cycle.
- Arbitration:
  - The data side has priority only when both sides request in IDLE.
  - An access in progress is never preempted.
- RAM contents are not cleared by reset.
- Reset (RST sampled high):
  - State IDLE, `cnt=0`.
  - `dwait=1`, `iwait=1`, `dload=0`, `iload=0`.
  - Reset mid-access discards the access; no write occurs.

## Timing
- Request first seen in IDLE in cycle 0 → completion (wait low) in cycle LAT+1 → IDLE in cycle LAT+2.
- Access period: LAT+2 cycles per access. An IDLE cycle may immediately capture a new or held request.
- Wait outputs and read data are combinational from state, `cnt`, request inputs and RAM. There is no registered delay after the completion condition.
- Write visibility: a write committed at the end of cycle N is visible to any read completing after cycle N.
- `LAT=0`: completion in cycle 1.

## Test plan
- Reset:
  - Stimulus: RST high for 2 cycles with all requests high.
  - Required: `dwait=1`, `iwait=1`, `dload=0`, `iload=0` in the cycle after RST drops.
  - Required: the request is first captured in the following IDLE cycle.
- Write then read, LAT=2:
  - Stimulus: `dWEN`, `daddr=0x40`, `dstore=0xDEADBEEF` from cycle 0.
  - Required: `dwait` low only in cycle 3.
  - Stimulus: then `dREN` at 0x40.
  - Required: `dload=0xDEADBEEF` in its completion cycle, 0 elsewhere.
- Arbitration, LAT=2:
  - Stimulus: `dREN` and `iREN` both asserted in cycle 0; `dREN` dropped in cycle 4.
  - Required: `dwait` low in cycle 3.
  - Required: `iwait` high through cycle 6 and low in cycle 7.
- Two-word writeback:
  - Stimulus: `dWEN` held continuously; addr 0x100/data 0x11, switched to 0x104/0x22 on the first `~dwait`.
  - Required: completions in cycles 3 and 7.
  - Required: reads of 0x100 and 0x104 return 0x11 and 0x22.
- Abort:
  - Stimulus: `dWEN` to 0x80 with 0x12345678, dropped in cycle 2 (before completion).
  - Required: no `dwait` low pulse.
  - Required: a later read of 0x80 returns its prior value.
- Reset mid-access:
  - Stimulus: RST high in cycle 2 of a write to 0x200.
  - Required: no write occurs.
  - Required: `dwait=1` in cycle 3.
  - Required: a read of 0x200 after reset returns the old value.
- Wrap-around, DEPTH_W=10:
  - Stimulus: write 0x55 to 0x1004.
  - Required: a read of 0x0004 returns 0x55.

Source files
------------

// File: rtl/mem_responder_if.sv
// ============================================================================
// mem_responder_if : cache-side request/wait bus for the memory responder
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_responder_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr,
    input  dload, dwait, iload, iwait
  );

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr,
    output dload, dwait, iload, iwait
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : word RAM answering data/instruction cache requests with a
//                 programmable latency and a one-cycle wait release
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int LAT     = 2,
  parameter int DEPTH_W = 10
) (
  input  wire logic     CLK,
  input  wire logic     RST,
  mem_responder_if.slave bus
);

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DBUSY = 2'd1,
    S_IBUSY = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 op_q, op_d;       // 1 = write
  logic [DEPTH_W-1:0]   aidx_q, aidx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 d_done, i_done;
  logic                 d_req;

  logic [31:0] mem_q [0:(2**DEPTH_W)-1];

  assign d_req = bus.dREN | bus.dWEN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    aidx_d  = aidx_q;
    wdata_d = wdata_q;
    d_done  = 1'b0;
    i_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_req) begin
          state_d = S_DBUSY;
          cnt_d   = LAT_CNT;
          op_d    = bus.dWEN;
          aidx_d  = bus.daddr[DEPTH_W+1:2];
          wdata_d = bus.dstore;
        end else if (bus.iREN) begin
          state_d = S_IBUSY;
          cnt_d   = LAT_CNT;
          op_d    = 1'b0;
          aidx_d  = bus.iaddr[DEPTH_W+1:2];
        end
      end
      S_DBUSY: begin
        if (!d_req) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          d_done  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_IBUSY: begin
        if (!bus.iREN) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          i_done  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 1'b0;
      aidx_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      aidx_q  <= aidx_d;
      wdata_q <= wdata_d;
    end
  end

  // RAM is deliberately outside reset; a reset edge suppresses a pending commit
  always_ff @(posedge CLK) begin
    if (!RST && d_done && op_q) begin
      mem_q[aidx_q] <= wdata_q;
    end
  end

  assign bus.dwait = ~d_done;
  assign bus.iwait = ~i_done;
  assign bus.dload = (d_done && !op_q) ? mem_q[aidx_q] : 32'd0;
  assign bus.iload = i_done ? mem_q[aidx_q] : 32'd0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.daddr[31:DEPTH_W+2], bus.daddr[1:0],
                              bus.iaddr[31:DEPTH_W+2], bus.iaddr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : cycle-by-cycle vector bench for mem_responder (LAT=2)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus ();

  mem_responder #(.LAT(2), .DEPTH_W(10)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    bit          chk;
    bit          rst;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [31:0] ds;
    bit          ir;
    logic [31:0] ia;
    bit          edw;
    bit          eiw;
    logic [31:0] edl;
    logic [31:0] eil;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(bit chk, bit r, bit dr, bit dw, logic [31:0] da,
                              logic [31:0] ds, bit ir, logic [31:0] ia,
                              bit edw, bit eiw, logic [31:0] edl, logic [31:0] eil);
    vec_t v;
    v.chk = chk; v.rst = r; v.dr = dr; v.dw = dw; v.da = da; v.ds = ds;
    v.ir = ir; v.ia = ia; v.edw = edw; v.eiw = eiw; v.edl = edl; v.eil = eil;
    return v;
  endfunction

  // Inputs are applied 1 ns after the rising edge, outputs sampled mid-cycle.
  task automatic apply(input vec_t v, input string name);
    rst        = v.rst;
    bus.dREN   = v.dr;
    bus.dWEN   = v.dw;
    bus.daddr  = v.da;
    bus.dstore = v.ds;
    bus.iREN   = v.ir;
    bus.iaddr  = v.ia;
    #4;
    if (v.chk) begin
      n_vec++;
      if (bus.dwait !== v.edw || bus.iwait !== v.eiw ||
          bus.dload !== v.edl || bus.iload !== v.eil) begin
        n_err++;
        $display("FAIL %s @%0t: got dwait=%b iwait=%b dload=%h iload=%h, want dwait=%b iwait=%b dload=%h iload=%h",
                 name, $time, bus.dwait, bus.iwait, bus.dload, bus.iload,
                 v.edw, v.eiw, v.edl, v.eil);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), name);
  endtask

  // Full LAT=2 data access: capture, two busy cycles, completion.
  task automatic d_access(input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_load,
                          input string name);
    for (int c = 0; c < 3; c++)
      apply(mk(1, 0, !wr, wr, addr, data, 0, 0, 1, 1, 0, 0), name);
    apply(mk(1, 0, !wr, wr, addr, data, 0, 0, 0, 1, exp_load, 0), name);
  endtask

  initial begin
    bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
    bus.iREN = 0; bus.iaddr = 0;
    @(posedge clk);
    #1;

    // reset with every request high, then write 0x40 (dWEN beats dREN)
    vecs.push_back(mk(0, 1, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'h40, 0, 1, 0, 0));
    // read back 0x40 while iREN still pending
    vecs.push_back(mk(1, 0, 1, 0, 32'h40, 0, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h40, 0, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h40, 0, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h40, 0, 1, 32'h40, 0, 1, 32'hDEADBEEF, 0));
    // arbitration: data first, instruction served once dREN drops
    vecs.push_back(mk(1, 0, 1, 0, 32'h40, 0, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h40, 0, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h40, 0, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h40, 0, 1, 32'h40, 0, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h40, 0, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h40, 0, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h40, 0, 1, 32'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h40, 0, 1, 32'h40, 1, 0, 0, 32'hDEADBEEF));
    // two-word writeback, dWEN held throughout
    vecs.push_back(mk(1, 0, 0, 1, 32'h100, 32'h11, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h100, 32'h11, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h100, 32'h11, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h100, 32'h11, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h104, 32'h22, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h104, 32'h22, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h104, 32'h22, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h104, 32'h22, 0, 0, 0, 1, 0, 0));
    // read 0x100; address moves to 0x104 mid-access and must be ignored
    vecs.push_back(mk(1, 0, 1, 0, 32'h100, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h104, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h104, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h104, 0, 0, 0, 0, 1, 32'h11, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h104, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h104, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h104, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h104, 0, 0, 0, 0, 1, 32'h22, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("table[%0d]", i));

    // abort: dWEN dropped before completion leaves 0x80 untouched
    d_access(1, 32'h80, 32'hAAAA0000, 0, "abort_setup");
    apply(mk(1, 0, 0, 1, 32'h80, 32'h12345678, 0, 0, 1, 1, 0, 0), "abort_c0");
    apply(mk(1, 0, 0, 1, 32'h80, 32'h12345678, 0, 0, 1, 1, 0, 0), "abort_c1");
    apply(mk(1, 0, 0, 0, 32'h80, 32'h12345678, 0, 0, 1, 1, 0, 0), "abort_c2");
    idle("abort_c3");
    idle("abort_c4");
    d_access(0, 32'h80, 0, 32'hAAAA0000, "abort_readback");

    // reset in cycle 2 of a write to 0x200
    d_access(1, 32'h200, 32'h00005A5A, 0, "rstmid_setup");
    apply(mk(1, 0, 0, 1, 32'h200, 32'h00000BAD, 0, 0, 1, 1, 0, 0), "rstmid_c0");
    apply(mk(1, 0, 0, 1, 32'h200, 32'h00000BAD, 0, 0, 1, 1, 0, 0), "rstmid_c1");
    apply(mk(0, 1, 0, 1, 32'h200, 32'h00000BAD, 0, 0, 1, 1, 0, 0), "rstmid_c2");
    apply(mk(1, 0, 0, 0, 32'h200, 32'h00000BAD, 0, 0, 1, 1, 0, 0), "rstmid_c3");
    idle("rstmid_c4");
    d_access(0, 32'h200, 0, 32'h00005A5A, "rstmid_readback");

    // wrap-around and ignored low address bits
    d_access(1, 32'h1004, 32'h55, 0, "wrap_write");
    d_access(0, 32'h0004, 0, 32'h55, "wrap_read");
    d_access(0, 32'hFFFF_F007, 0, 32'h55, "wrap_read_hi");
    idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
